lu_iter_32b: RTL and testbench

- Multi-cycle, slice-iterative 32-bit logical unit for the ALU datapath: the sequential responder counterpart to the single-cycle bitwise gates.
- Accepts an operand pair and opcode over a valid/ready request channel.
- Computes SLICE result bits per clock, least-significant slice first.
- Returns the full WIDTH-bit result on a valid/ready response channel to the ALU control sequencer.

---
 rtl/lu_iter_32b.sv | 157 +++++++++++++++
 tb/tb_lu_iter_32b.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lu_iter_32b.sv
// lu_iter_32b: multi-cycle, slice-iterative WIDTH-bit logical unit.
// A request (a, b, op) is accepted over a valid/ready channel in IDLE. RUN then
// produces SLICE result bits per clock, least-significant slice first. The full
// result is offered in DONE on a valid/ready response channel until consumed.
// Opcodes: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored).
// Optional feature: define LU_ZERO_FLAG_EN to add a registered 'zero' output.
// It is high in DONE iff the result is all zeros.
module lu_iter_32b #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef LU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  op_e              op_lat;
  logic [WIDTH-1:0] full_res;
  logic [SLICE-1:0] cur_slice;
  logic             last_slice;
`ifdef LU_ZERO_FLAG_EN
  logic             zero_acc;
`endif

  // Bitwise function of the latched operands; no carries, so each slice is independent.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    full_res = '0;
    case (op_lat)
      OP_AND:  full_res = a_lat & b_lat;
      OP_OR:   full_res = a_lat | b_lat;
      OP_XOR:  full_res = a_lat ^ b_lat;
      OP_NOT:  full_res = ~a_lat;
      default: full_res = '0;
    endcase
  end

  // Select the slice addressed by the counter; constant-index loop avoids variable part-selects.
  always_comb begin
    cur_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) cur_slice = full_res[i*SLICE +: SLICE];
    end
    last_slice = (cnt == CW'(NSLICE - 1));
  end

  // Control FSM with registered handshake outputs, operand latches and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: result and operand latches are plain registers, so they are reset like all other state.
      state     <= S_IDLE;
      cnt       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      op_lat    <= OP_AND;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef LU_ZERO_FLAG_EN
      zero_acc  <= 1'b0;
      zero      <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_lat    <= a;
            b_lat    <= b;
            op_lat   <= op_e'(op);
            result   <= '0;
            cnt      <= '0;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef LU_ZERO_FLAG_EN
            zero_acc <= 1'b1;
`endif
          end
        end

        S_RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) result[i*SLICE +: SLICE] <= cur_slice;
          end
`ifdef LU_ZERO_FLAG_EN
          zero_acc <= zero_acc & (cur_slice == '0);
`endif
          if (last_slice) begin
            cnt       <= '0;
            state     <= S_DONE;
            out_valid <= 1'b1;
`ifdef LU_ZERO_FLAG_EN
            zero      <= zero_acc & (cur_slice == '0);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          // Hold result and out_valid for as long as the consumer backpressures.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef LU_ZERO_FLAG_EN
            zero      <= 1'b0;
`endif
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lu_iter_32b.sv
// tb_lu_iter_32b: directed and randomized bench for lu_iter_32b.
// Expected values come from a plain bitwise reference model plus a slice mask
// describing which result bits have been written so far.
module tb_lu_iter_32b;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;
`ifdef LU_ZERO_FLAG_EN
  logic             zero;
`endif

  int vectors;
  int miscompares;

  lu_iter_32b #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef LU_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the full result of an operation.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic [1:0]       mop);
    case (mop)
      2'b00:   return ma & mb;
      2'b01:   return ma | mb;
      2'b10:   return ma ^ mb;
      default: return ~ma;
    endcase
  endfunction

  // Bits written after n RUN edges (low n slices).
  function automatic logic [WIDTH-1:0] written_mask(input int n);
    logic [63:0] m;
    m = (64'd1 << (SLICE * n)) - 64'd1;
    return m[WIDTH-1:0];
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".busy"},      {31'd0, busy},      32'd0);
`ifdef LU_ZERO_FLAG_EN
    check({tag, ".zero"},      {31'd0, zero},      32'd0);
`endif
  endtask

  // Count edges until out_valid, checking partial progress on each RUN edge.
  task automatic wait_done(input logic [WIDTH-1:0] exp, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n < NSLICE) begin
        check("partial", result, exp & written_mask(n));
        check("run.in_ready", {31'd0, in_ready}, 32'd0);
`ifdef LU_ZERO_FLAG_EN
        check("run.zero", {31'd0, zero}, 32'd0);
`endif
      end
    end
    check("latency", n, NSLICE);
  endtask

  // Consume the result and confirm the return to IDLE.
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle("post_handshake");
  endtask

  // One complete transaction with optional DONE stall and input scrambling during RUN.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic [1:0] top, input int stall, input bit scramble);
    logic [WIDTH-1:0] exp;
    int n;
    exp      = model(ta, tb, top);
    a        = ta;
    b        = tb;
    op       = top;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept.busy", {31'd0, busy}, 32'd1);
    check("accept.cleared", result, '0);
    if (scramble) begin
      a        = 32'hFFFF_FFFF;
      b        = $urandom;
      op       = 2'($urandom_range(0, 3));
      in_valid = 1'b1;
    end
    wait_done(exp, n);
    in_valid = 1'b0;
    check("done.result", result, exp);
`ifdef LU_ZERO_FLAG_EN
    check("done.zero", {31'd0, zero}, {31'd0, (exp == '0)});
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall.out_valid", {31'd0, out_valid}, 32'd1);
      check("stall.result", result, exp);
    end
    handshake();
  endtask

  initial begin
    logic [WIDTH-1:0] exp;
    int n;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    op          = 2'b00;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check_idle("reset");
    check("reset.result", result, '0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("idle");

    // Directed operations on the spec operands, including NOT with garbage b and RUN scrambling.
    do_op(32'hCA98_1547, 32'h3567_EAB9, 2'b00, 0, 1'b0);
    do_op(32'hCA98_1547, 32'h3567_EAB9, 2'b01, 0, 1'b0);
    do_op(32'hCA98_1547, 32'h3567_EAB9, 2'b10, 0, 1'b0);
    do_op(32'hCA98_1547, 32'hDEAD_BEEF, 2'b11, 0, 1'b1);

    // Backpressure for 10 cycles with a second request already waiting.
    a = 32'h1234_5678; b = 32'h0F0F_00FF; op = 2'b10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(model(32'h1234_5678, 32'h0F0F_00FF, 2'b10), n);
    exp = model(32'h1234_5678, 32'h0F0F_00FF, 2'b10);
    a = 32'hA5A5_A5A5; b = 32'h00FF_FF00; op = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.result", result, exp);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle("bp.release");
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.second_accept", {31'd0, busy}, 32'd1);
    check("bp.second_cleared", result, '0);
    wait_done(model(32'hA5A5_A5A5, 32'h00FF_FF00, 2'b01), n);
    check("bp.second_result", result, model(32'hA5A5_A5A5, 32'h00FF_FF00, 2'b01));
    handshake();

    // Asynchronous reset two RUN edges into an operation.
    a = 32'hFFFF_FFFF; b = 32'h1234_5678; op = 2'b00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    check("midreset.result", result, '0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midreset.no_valid", {31'd0, out_valid}, 32'd0);
    end
    do_op(32'hFFFF_FFFF, 32'h0000_FFFF, 2'b00, 0, 1'b0);

`ifdef LU_ZERO_FLAG_EN
    do_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00, 2, 1'b0);
    do_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b01, 2, 1'b0);
    do_op(32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 0, 1'b0);
    do_op(32'h0000_0100, 32'h0000_0000, 2'b01, 0, 1'b0);
`endif

    // Randomized transactions with random stalls and RUN-time input noise.
    for (int t = 0; t < 40; t++) begin
      do_op($urandom, $urandom, 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
